conv_mac_accum: RTL and testbench

- Downstream stage of the vedic16x16 multiplier in the convolution datapath.
- Consumes the 32-bit unsigned product stream, one product per handshake.
- Accumulates TAPS consecutive products into one convolution output sample.
- Presents the sum on a valid/ready output port to the activation/writeback stage.

---
 rtl/conv_pkg.sv | 39 +++
 rtl/conv_tap_counter.sv | 25 ++
 rtl/conv_mac_accum.sv | 93 +++++++++
 tb/tb_conv_mac_accum.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and arithmetic for the convolution MAC accumulator.
// CONV_ACC_SAT_EN: when defined, sat_add clamps the sum to all ones on carry.
package conv_pkg;

  localparam int PROD_W        = 32;
  localparam int ACC_W_DEFAULT = 40;
  localparam int TAPS_DEFAULT  = 9;
  // Widest accumulator sat_add can serve; ACC_W must lie in PROD_W..ACC_MAX_W.
  localparam int ACC_MAX_W     = 64;

  typedef enum logic {
    ACC,
    HOLD
  } conv_acc_state_t;

  // Adds two values already confined to w bits; returns {carry, sum} with the
  // sum in the low w bits. Under CONV_ACC_SAT_EN the sum clamps to all ones.
  function automatic logic [ACC_MAX_W:0] sat_add(
    input logic [ACC_MAX_W-1:0] acc,
    input logic [ACC_MAX_W-1:0] prod,
    input int                   w
  );
    logic [ACC_MAX_W:0]   full;
    logic [ACC_MAX_W-1:0] mask;
    logic [ACC_MAX_W-1:0] sum;
    logic                 carry;
    full  = {1'b0, acc} + {1'b0, prod};
    mask  = (ACC_MAX_W'(1) << w) - ACC_MAX_W'(1);
    carry = |(full >> w);
    sum   = full[ACC_MAX_W-1:0] & mask;
`ifdef CONV_ACC_SAT_EN
    if (carry) sum = mask;
`else
    sum = sum;
`endif
    return {carry, sum};
  endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// Modulo-TAPS counter; wrap flags the last count, where the next inc returns to 0.
module conv_tap_counter
  import conv_pkg::*;
#(
  parameter int TAPS = TAPS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] count,
  output logic       wrap
);

  assign wrap = (count == 8'(TAPS - 1));

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (inc) begin
      count <= wrap ? 8'd0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/conv_mac_accum.sv
// Accumulates TAPS unsigned products into one output sample on a valid/ready port.
// CONV_ACC_SAT_EN: when defined, overflowing windows saturate to all ones.
module conv_mac_accum
  import conv_pkg::*;
#(
  parameter int TAPS  = TAPS_DEFAULT,
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic [7:0]        tap_idx
);

  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic               last;
  logic               in_xfer;
  logic               out_xfer;
  logic [ACC_MAX_W:0] add_res;
  logic [ACC_W-1:0]   sum_next;
  logic               carry;
  logic               unused_hi;
  conv_acc_state_t    state;

  // Only the completing tap waits for a stalled sample; earlier taps keep flowing.
  assign in_ready = !(out_valid && !out_ready && last);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  assign add_res   = sat_add(ACC_MAX_W'(acc), ACC_MAX_W'(in_product), ACC_W);
  assign sum_next  = add_res[ACC_W-1:0];
  assign carry     = add_res[ACC_MAX_W];
  assign unused_hi = |(add_res[ACC_MAX_W-1:0] >> ACC_W);

  conv_tap_counter #(
    .TAPS (TAPS)
  ) u_tap_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (in_xfer),
    .count (tap_idx),
    .wrap  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (in_xfer) begin
        if (last) begin
          out_sum   <= sum_next;
          out_ovf   <= ovf | carry;
          out_valid <= 1'b1;
          acc       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= sum_next;
          ovf <= ovf | carry;
        end
      end
      // A completing tap in the same cycle reloads the sample with no gap.
      if (out_xfer && !(in_xfer && last)) out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      case (state)
        ACC:     if (out_valid && !out_ready && in_valid && last) state <= HOLD;
        HOLD:    if (out_ready) state <= ACC;
        default: state <= ACC;
      endcase
    end
  end

  // While held, the pending sample and the completing tap must both stay put.
  hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state == HOLD) |-> (out_valid && last));

endmodule

// File: tb/tb_conv_mac_accum.sv
// Scoreboard bench for conv_mac_accum (TAPS=4, ACC_W=33) with a window-sum model.
module tb_conv_mac_accum;

  localparam int TAPS  = 4;
  localparam int ACC_W = 33;

  typedef struct {
    logic [63:0] sum;
    logic        ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;
  logic [7:0]        tap_idx;

  exp_t              sb_q[$];
  int                tests = 0;
  int                fails = 0;
  int                rx_cnt = 0;
  int                stall_cnt = 0;
  longint unsigned   win_total = 0;
  int                win_n = 0;
  bit                rand_rdy = 1'b0;
  logic [63:0]       acc_mask;

  conv_mac_accum #(
    .TAPS  (TAPS),
    .ACC_W (ACC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_ovf    (out_ovf),
    .tap_idx    (tap_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a window is the plain sum of TAPS products; it overflowed if the
  // true total reaches 2^ACC_W, and the reported value wraps or saturates.
  task automatic model_accept(input logic [31:0] p);
    exp_t e;
    win_total += longint'(p);
    win_n++;
    if (win_n == TAPS) begin
      e.ovf = (win_total >= (64'd1 << ACC_W));
      e.sum = win_total & acc_mask;
`ifdef CONV_ACC_SAT_EN
      if (e.ovf) e.sum = acc_mask;
`endif
      sb_q.push_back(e);
      win_total = 0;
      win_n     = 0;
    end
  endtask

  // Presents one product and returns 1 time unit after the edge that took it.
  task automatic send(input logic [31:0] p);
    int waits = 0;
    in_valid   = 1'b1;
    in_product = p;
    @(negedge clk);
    while (!in_ready) begin
      waits++;
      if (waits > 1000) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, expected acceptance", waits);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    model_accept(p);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on every output transfer, checks hold stability.
  initial begin
    bit               held = 1'b0;
    logic [ACC_W-1:0] held_sum;
    logic             held_ovf;
    exp_t             e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_sum_stable", 64'(out_sum), 64'(held_sum));
        check("hold_ovf_stable", 64'(out_ovf), 64'(held_ovf));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_sample: got sum 0x%0h, expected no sample", out_sum);
        end else begin
          e = sb_q.pop_front();
          check("sample_sum", 64'(out_sum), e.sum);
          check("sample_ovf", 64'(out_ovf), 64'(e.ovf));
        end
        rx_cnt++;
      end
      held     = out_valid && !out_ready;
      held_sum = out_sum;
      held_ovf = out_ovf;
      if (in_valid && !in_ready) stall_cnt++;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r0;
    int k;
    logic [31:0] p;
    acc_mask   = (64'd1 << ACC_W) - 64'd1;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_product = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_tap_idx", 64'(tap_idx), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single window, latency and no stall.
    s0 = stall_cnt;
    send(32'd124560);
    send(32'd1);
    send(32'd2);
    check("t1_valid_before_last", 64'(out_valid), 64'd0);
    check("t1_tap_idx_3", 64'(tap_idx), 64'd3);
    send(32'd3);
    in_valid = 1'b0;
    check("t1_valid_latency", 64'(out_valid), 64'd1);
    check("t1_sum", 64'(out_sum), 64'd124566);
    check("t1_ovf", 64'(out_ovf), 64'd0);
    check("t1_tap_wrap", 64'(tap_idx), 64'd0);
    check("t1_no_stall", 64'(stall_cnt - s0), 64'd0);
    @(posedge clk);
    #1;
    check("t1_valid_cleared", 64'(out_valid), 64'd0);

    // Two back-to-back windows.
    s0 = stall_cnt;
    r0 = rx_cnt;
    for (int i = 0; i < 8; i++) begin
      send(32'h0001_0000);
      if (i == 3) check("t2_tap_wrap", 64'(tap_idx), 64'd0);
      if (i == 6) check("t2_tap_idx_3", 64'(tap_idx), 64'd3);
    end
    in_valid = 1'b0;
    check("t2_sum", 64'(out_sum), 64'h4_0000);
    check("t2_no_stall", 64'(stall_cnt - s0), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("t2_two_samples", 64'(rx_cnt - r0), 64'd2);

    // Backpressure: only the completing tap of window 2 stalls.
    out_ready = 1'b0;
    s0 = stall_cnt;
    r0 = rx_cnt;
    send(32'd100); send(32'd200); send(32'd300); send(32'd400);
    send(32'd7); send(32'd8); send(32'd9);
    in_valid   = 1'b1;
    in_product = 32'd10;
    repeat (3) begin
      @(negedge clk);
      check("t3_stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    check("t3_held_sum", 64'(out_sum), 64'd1000);
    check("t3_stall_cycles", 64'(stall_cnt - s0), 64'd3);
    check("t3_no_early_rx", 64'(rx_cnt - r0), 64'd0);
    out_ready = 1'b1;
    send(32'd10);
    in_valid = 1'b0;
    check("t3_valid_no_gap", 64'(out_valid), 64'd1);
    check("t3_second_sum", 64'(out_sum), 64'd34);
    repeat (2) begin @(posedge clk); #1; end
    check("t3_both_delivered", 64'(rx_cnt - r0), 64'd2);

    // Overflow of a 33-bit accumulator, then a clean window.
    repeat (4) send(32'hFFFF_FFFF);
    in_valid = 1'b0;
    check("t4_ovf", 64'(out_ovf), 64'd1);
`ifdef CONV_ACC_SAT_EN
    check("t4_sum", 64'(out_sum), 64'h1_FFFF_FFFF);
`else
    check("t4_sum", 64'(out_sum), 64'h1_FFFF_FFFC);
`endif
    repeat (4) send(32'd1);
    in_valid = 1'b0;
    check("t4_ovf_cleared", 64'(out_ovf), 64'd0);
    check("t4_clean_sum", 64'(out_sum), 64'd4);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-window with a pending sample.
    out_ready = 1'b0;
    repeat (4) send(32'd50);
    send(32'd6);
    send(32'd7);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_sum", 64'(out_sum), 64'd0);
    check("t5_rst_ovf", 64'(out_ovf), 64'd0);
    check("t5_rst_tap_idx", 64'(tap_idx), 64'd0);
    check("t5_rst_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    win_total = 0;
    win_n     = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) send(32'd5);
    in_valid = 1'b0;
    check("t5_sum_after_reset", 64'(out_sum), 64'd20);
    @(posedge clk);
    #1;

    // Random products, in_valid toggling, random out_ready, 100 windows.
    r0 = rx_cnt;
    rand_rdy = 1'b1;
    for (int w = 0; w < 100; w++) begin
      for (int t = 0; t < TAPS; t++) begin
        case ($urandom_range(0, 2))
          0:       p = 32'($urandom_range(0, 1 << 20));
          1:       p = $urandom;
          default: p = $urandom | 32'h8000_0000;
        endcase
        send(p);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("t6_drained", 64'(sb_q.size()), 64'd0);
    check("t6_rx_count", 64'(rx_cnt - r0), 64'd100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
